// File: rtl/pad_bank_seq.sv
// Per-IO-bank pad power sequencer: debounces bank POK, enables pad input buffers, then releases gated output enables.
// Optional feature: define PAD_BANK_SEQ_POK_SYNC_EN to pass each pok_raw_i bit through a 2-flop synchroniser.
//
// Handshake-free block: every input is a level, except fault_clr_i, which is a single-cycle pulse per bank.
// Every output is a registered decode, except pad_oe_o, which also ANDs in oe_i combinationally.
module pad_bank_seq #(
    parameter int unsigned NPads          = 8,
    parameter int unsigned NIoBanks       = 4,
    parameter logic [NPads-1:0][$clog2(NIoBanks):0] PadBank = '0,
    parameter int unsigned DebounceCycles = 16,
    parameter int unsigned SettleCycles   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NIoBanks-1:0]       pok_raw_i,
    input  logic [NIoBanks-1:0]       bank_en_i,
    input  logic [NIoBanks-1:0]       fault_clr_i,
    input  logic [NPads-1:0]          oe_i,
    output logic [NPads-1:0]          pad_ie_o,
    output logic [NPads-1:0]          pad_oe_o,
    output logic [NIoBanks-1:0]       bank_ready_o,
    output logic [NIoBanks-1:0]       bank_fault_o,
    output logic [NIoBanks-1:0][2:0]  dbg_state_o
);

    localparam int unsigned MaxCycles = (DebounceCycles > SettleCycles) ? DebounceCycles : SettleCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_WAIT_POK = 3'd1;
    localparam logic [2:0] ST_SETTLE   = 3'd2;
    localparam logic [2:0] ST_READY    = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

    localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] SetLast = CntW'(SettleCycles - 1);

    logic [NIoBanks-1:0] w_pok;
    logic [NIoBanks-1:0] w_bank_ie;
    logic [NIoBanks-1:0] w_bank_oe;

`ifdef PAD_BANK_SEQ_POK_SYNC_EN
    logic [NIoBanks-1:0] r_pok_meta;
    logic [NIoBanks-1:0] r_pok_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pok_meta <= '0;
            r_pok_sync <= '0;
        end else begin
            r_pok_meta <= pok_raw_i;
            r_pok_sync <= r_pok_meta;
        end
    end

    assign w_pok = r_pok_sync;
`else
    assign w_pok = pok_raw_i;
`endif

    for (genvar b = 0; b < NIoBanks; b++) begin : g_bank
        logic [2:0]      r_state;
        logic [2:0]      w_state_nxt;
        logic [CntW-1:0] r_cnt;
        logic [CntW-1:0] w_cnt_nxt;
        logic            r_fault;
        logic            w_fault_nxt;
        logic            w_pok_loss;

        // POK loss outranks bank_en_i, which outranks counter expiry.
        always_comb begin
            w_state_nxt = r_state;
            w_pok_loss  = 1'b0;
            case (r_state)
                ST_OFF: begin
                    if (bank_en_i[b]) w_state_nxt = ST_WAIT_POK;
                end
                ST_WAIT_POK: begin
                    if (!bank_en_i[b])                   w_state_nxt = ST_OFF;
                    else if (w_pok[b] && r_cnt == DebLast) w_state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!w_pok[b])              w_pok_loss  = 1'b1;
                    else if (!bank_en_i[b])     w_state_nxt = ST_OFF;
                    else if (r_cnt == SetLast)  w_state_nxt = ST_READY;
                end
                ST_READY: begin
                    if (!w_pok[b])              w_pok_loss  = 1'b1;
                    else if (!bank_en_i[b])     w_state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!w_pok[b])              w_pok_loss  = 1'b1;
                    else if (r_cnt == SetLast)  w_state_nxt = bank_en_i[b] ? ST_WAIT_POK : ST_OFF;
                end
                default: w_state_nxt = ST_OFF;
            endcase
            if (w_pok_loss) w_state_nxt = bank_en_i[b] ? ST_WAIT_POK : ST_OFF;
        end

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (w_state_nxt != r_state) begin
                w_cnt_nxt = '0;
            end else if (r_state == ST_WAIT_POK && !w_pok[b]) begin
                w_cnt_nxt = '0;
            end else if (r_state == ST_WAIT_POK || r_state == ST_SETTLE || r_state == ST_DRAIN) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end

        // A loss and a clear in the same cycle leave the fault set.
        always_comb begin
            w_fault_nxt = r_fault;
            if (w_pok_loss)          w_fault_nxt = 1'b1;
            else if (fault_clr_i[b]) w_fault_nxt = 1'b0;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state <= ST_OFF;
                r_cnt   <= '0;
                r_fault <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_fault <= w_fault_nxt;
            end
        end

        assign w_bank_ie[b]    = (r_state == ST_SETTLE) || (r_state == ST_READY) || (r_state == ST_DRAIN);
        assign w_bank_oe[b]    = (r_state == ST_READY);
        assign bank_ready_o[b] = (r_state == ST_READY);
        assign bank_fault_o[b] = r_fault;
        assign dbg_state_o[b]  = r_state;
    end

    // Pads mapped to a bank index beyond NIoBanks are never enabled.
    for (genvar k = 0; k < NPads; k++) begin : g_pad
        localparam int unsigned BankIdx = 32'(PadBank[k]);
        if (BankIdx < NIoBanks) begin : g_mapped
            assign pad_ie_o[k] = w_bank_ie[BankIdx];
            assign pad_oe_o[k] = oe_i[k] & w_bank_oe[BankIdx];
        end else begin : g_unmapped
            assign pad_ie_o[k] = 1'b0;
            assign pad_oe_o[k] = 1'b0;
        end
    end

endmodule

// File: tb/tb_pad_bank_seq.sv
// Bench for pad_bank_seq: two instances (the reference pad map and one with unmapped pads) checked each cycle
// against a per-bank phase/age model, plus hand-computed literal points on the directed sequences.
module tb_pad_bank_seq;

    localparam int NP  = 4;
    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int SET = 3;
    localparam logic [NP-1:0][1:0] MAP_A = {2'd1, 2'd1, 2'd0, 2'd0};
    localparam logic [NP-1:0][1:0] MAP_U = {2'd3, 2'd2, 2'd0, 2'd1};

    localparam int P_OFF  = 0;
    localparam int P_WAIT = 1;
    localparam int P_SET  = 2;
    localparam int P_RDY  = 3;
    localparam int P_DRN  = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [NB-1:0] pok_raw_i = '0;
    logic [NB-1:0] bank_en_i = '0;
    logic [NB-1:0] fault_clr_i = '0;
    logic [NP-1:0] oe_i = '0;

    logic [NP-1:0]      ie_a, oe_a, ie_u, oe_u;
    logic [NB-1:0]      rdy_a, flt_a, rdy_u, flt_u;
    logic [NB-1:0][2:0] dbg_a, dbg_u;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    pad_bank_seq #(.NPads(NP), .NIoBanks(NB), .PadBank(MAP_A), .DebounceCycles(DEB), .SettleCycles(SET)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pok_raw_i(pok_raw_i), .bank_en_i(bank_en_i),
        .fault_clr_i(fault_clr_i), .oe_i(oe_i), .pad_ie_o(ie_a), .pad_oe_o(oe_a),
        .bank_ready_o(rdy_a), .bank_fault_o(flt_a), .dbg_state_o(dbg_a));

    pad_bank_seq #(.NPads(NP), .NIoBanks(NB), .PadBank(MAP_U), .DebounceCycles(DEB), .SettleCycles(SET)) dut_u (
        .clk_i(clk_i), .rst_i(rst_i), .pok_raw_i(pok_raw_i), .bank_en_i(bank_en_i),
        .fault_clr_i(fault_clr_i), .oe_i(oe_i), .pad_ie_o(ie_u), .pad_oe_o(oe_u),
        .bank_ready_o(rdy_u), .bank_fault_o(flt_u), .dbg_state_o(dbg_u));

    // ---------------- behavioural model ----------------
    int m_phase[NB];
    int m_age[NB];
    int m_run[NB];
    bit m_fault[NB];
`ifdef PAD_BANK_SEQ_POK_SYNC_EN
    logic [NB-1:0] m_s1 = '0;
    logic [NB-1:0] m_s2 = '0;
`endif

    initial begin
        for (int b = 0; b < NB; b++) begin
            m_phase[b] = P_OFF; m_age[b] = 0; m_run[b] = 0; m_fault[b] = 1'b0;
        end
    end

    always @(posedge clk_i) begin
        logic [NB-1:0] pv;
        int nph;
        bit live;
        if (rst_i) begin
            for (int b = 0; b < NB; b++) begin
                m_phase[b] = P_OFF; m_age[b] = 0; m_run[b] = 0; m_fault[b] = 1'b0;
            end
`ifdef PAD_BANK_SEQ_POK_SYNC_EN
            m_s1 = '0; m_s2 = '0;
`endif
        end else begin
`ifdef PAD_BANK_SEQ_POK_SYNC_EN
            pv = m_s2; m_s2 = m_s1; m_s1 = pok_raw_i;
`else
            pv = pok_raw_i;
`endif
            for (int b = 0; b < NB; b++) begin
                nph  = m_phase[b];
                live = (m_phase[b] == P_SET) || (m_phase[b] == P_RDY) || (m_phase[b] == P_DRN);
                if (live && !pv[b]) begin
                    nph = bank_en_i[b] ? P_WAIT : P_OFF;
                    m_fault[b] = 1'b1;
                end else begin
                    if (fault_clr_i[b]) m_fault[b] = 1'b0;
                    case (m_phase[b])
                        P_OFF:  if (bank_en_i[b]) nph = P_WAIT;
                        P_WAIT: begin
                            if (!bank_en_i[b]) nph = P_OFF;
                            else if (pv[b]) begin
                                m_run[b]++;
                                if (m_run[b] == DEB) nph = P_SET;
                            end else m_run[b] = 0;
                        end
                        P_SET:  if (!bank_en_i[b]) nph = P_OFF; else if (m_age[b] + 1 == SET) nph = P_RDY;
                        P_RDY:  if (!bank_en_i[b]) nph = P_DRN;
                        P_DRN:  if (m_age[b] + 1 == SET) nph = bank_en_i[b] ? P_WAIT : P_OFF;
                        default: nph = P_OFF;
                    endcase
                end
                if (nph != m_phase[b]) begin
                    m_phase[b] = nph; m_age[b] = 0; m_run[b] = 0;
                end else m_age[b]++;
            end
        end
    end

    function automatic logic [NP-1:0] exp_pad(input bit use_u, input bit want_oe);
        logic [NP-1:0] r;
        int bk;
        r = '0;
        for (int k = 0; k < NP; k++) begin
            bk = use_u ? int'(MAP_U[k]) : int'(MAP_A[k]);
            if (bk < NB) begin
                if (want_oe) r[k] = oe_i[k] && (m_phase[bk] == P_RDY);
                else         r[k] = (m_phase[bk] == P_SET) || (m_phase[bk] == P_RDY) || (m_phase[bk] == P_DRN);
            end
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] exp_ready();
        logic [NB-1:0] r;
        for (int b = 0; b < NB; b++) r[b] = (m_phase[b] == P_RDY);
        return r;
    endfunction

    function automatic logic [NB-1:0] exp_fault();
        logic [NB-1:0] r;
        for (int b = 0; b < NB; b++) r[b] = m_fault[b];
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("a_pad_ie", 32'(ie_a), 32'(exp_pad(1'b0, 1'b0)));
            check("a_pad_oe", 32'(oe_a), 32'(exp_pad(1'b0, 1'b1)));
            check("a_ready",  32'(rdy_a), 32'(exp_ready()));
            check("a_fault",  32'(flt_a), 32'(exp_fault()));
            check("u_pad_ie", 32'(ie_u), 32'(exp_pad(1'b1, 1'b0)));
            check("u_pad_oe", 32'(oe_u), 32'(exp_pad(1'b1, 1'b1)));
            check("u_ready",  32'(rdy_u), 32'(exp_ready()));
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_ie",    32'(ie_a),  32'h0);
        check("rst_oe",    32'(oe_a),  32'h0);
        check("rst_ready", 32'(rdy_a), 32'h0);
        check("rst_fault", 32'(flt_a), 32'h0);

        // power-up of bank 0, cycle 0 starts here
        rst_i = 1'b0; pok_raw_i = 2'b11; oe_i = 4'hF; bank_en_i = 2'b01;
        repeat (4) tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("pu_ie_c4", 32'(ie_a), 32'h0);
`endif
        tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("pu_ie_c5", 32'(ie_a), 32'b0011);
        check("pu_oe_c5", 32'(oe_a), 32'b0000);
`endif
        repeat (2) tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("pu_rdy_c7", 32'(rdy_a), 32'b00);
`endif
        tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("pu_oe_c8",   32'(oe_a),  32'b0011);
        check("pu_rdy_c8",  32'(rdy_a), 32'b01);
        check("pu_u_ie_c8", 32'(ie_u),  32'b0010);
        check("pu_u_oe_c8", 32'(oe_u),  32'b0010);
`endif
        // POK loss in READY
        pok_raw_i = 2'b10;
        tick();
        pok_raw_i = 2'b11;
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("loss_ie",    32'(ie_a),  32'h0);
        check("loss_oe",    32'(oe_a),  32'h0);
        check("loss_fault", 32'(flt_a), 32'b01);
`endif
        repeat (7) tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("reseq_rdy",   32'(rdy_a), 32'b01);
        check("reseq_fault", 32'(flt_a), 32'b01);
`endif
        fault_clr_i = 2'b01;
        tick();
        fault_clr_i = 2'b00;
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("clr_fault", 32'(flt_a), 32'b00);
`endif
        // drain
        bank_en_i = 2'b00;
        tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("drain_oe_t1", 32'(oe_a), 32'h0);
        check("drain_ie_t1", 32'(ie_a), 32'b0011);
`endif
        repeat (2) tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("drain_ie_t3", 32'(ie_a), 32'b0011);
`endif
        tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("drain_ie_t4", 32'(ie_a), 32'h0);
`endif
        // debounce glitch: two highs, one low, then high
        bank_en_i = 2'b01;
        repeat (3) tick();
        pok_raw_i = 2'b10;
        tick();
        pok_raw_i = 2'b11;
        repeat (3) tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("glitch_ie_early", 32'(ie_a), 32'h0);
`endif
        tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("glitch_ie", 32'(ie_a), 32'b0011);
`endif
        repeat (3) tick();
        // simultaneous clear and loss
        pok_raw_i = 2'b10; fault_clr_i = 2'b01;
        tick();
        pok_raw_i = 2'b11; fault_clr_i = 2'b00;
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("simul_fault", 32'(flt_a), 32'b01);
`endif
        repeat (4) tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("settle_ie", 32'(ie_a), 32'b0011);
        check("settle_oe", 32'(oe_a), 32'h0);
`endif
        bank_en_i = 2'b00;
        tick();
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("settle_off_ie", 32'(ie_a), 32'h0);
        check("settle_off_oe", 32'(oe_a), 32'h0);
`endif
        // both banks up, then reset
        bank_en_i = 2'b11;
        repeat (8) tick();
        oe_i = 4'b1010;
        #1;
`ifndef PAD_BANK_SEQ_POK_SYNC_EN
        check("both_rdy",   32'(rdy_a), 32'b11);
        check("both_fault", 32'(flt_a), 32'b01);
        check("both_oe",    32'(oe_a),  32'b1010);
        check("both_u_oe",  32'(oe_u),  32'b0010);
        check("both_u_ie",  32'(ie_u),  32'b0011);
`endif
        rst_i = 1'b1;
        tick();
        check("mid_rst_ie",    32'(ie_a),  32'h0);
        check("mid_rst_oe",    32'(oe_a),  32'h0);
        check("mid_rst_ready", 32'(rdy_a), 32'h0);
        check("mid_rst_fault", 32'(flt_a), 32'h0);
        rst_i = 1'b0; bank_en_i = 2'b00;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 15) == 0) bank_en_i[b] = ~bank_en_i[b];
                pok_raw_i[b]   = ($urandom_range(0, 24) != 0);
                fault_clr_i[b] = ($urandom_range(0, 9) == 0);
            end
            oe_i = 4'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
